// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared external ALU: IDLE/EXEC/DONE sequencer, one op in flight.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed priority (req0 wins).
module alu_arbiter #(
    parameter int WIDTH = 16,
    parameter int OPW   = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [OPW-1:0]   op0,
    input  logic [OPW-1:0]   op1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             err0,
    output logic             err1,
    output logic [WIDTH-1:0] result0,
    output logic [WIDTH-1:0] result1,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_out,
    output logic             busy,
    output logic [15:0]      op_count,
    output logic [1:0]       state_dbg
);

    // Handshake: a requester holds req/op/a/b stable until its one-cycle gnt pulse;
    // req is only looked at in IDLE, and the matching done pulse follows gnt by one cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic             accept;
    logic             pick1;
    logic [OPW-1:0]   op_sel;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic             legal_sel;
    logic             win_q;
    logic             illegal_q;

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req0 || req1) state_d = EXEC;
            EXEC:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign accept = (state_q == IDLE) && (req0 || req1);

`ifdef ALU_ARB_ROUND_ROBIN_EN
    // last_q = 1 means requester 1 was granted most recently, so requester 0 wins the next tie.
    logic last_q;

    assign pick1 = req1 && (!req0 || !last_q);

    always_ff @(posedge clock) begin
        if (reset)       last_q <= 1'b1;
        else if (accept) last_q <= pick1;
    end
`else
    assign pick1 = req1 && !req0;
`endif

    assign op_sel    = pick1 ? op1 : op0;
    assign a_sel     = pick1 ? a1  : a0;
    assign b_sel     = pick1 ? b1  : b0;
    assign legal_sel = (op_sel <= OPW'(4));

    always_ff @(posedge clock) begin
        if (reset) begin
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            result0   <= '0;
            result1   <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            op_count  <= 16'd0;
            win_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        win_q     <= pick1;
                        illegal_q <= !legal_sel;
                        gnt0      <= !pick1;
                        gnt1      <= pick1;
                        // Illegal opcodes never reach the ALU; its inputs keep the last legal op.
                        if (legal_sel) begin
                            alu_a  <= a_sel;
                            alu_b  <= b_sel;
                            alu_op <= op_sel;
                        end
                    end
                end
                EXEC: begin
                    if (win_q) begin
                        done1   <= 1'b1;
                        err1    <= illegal_q;
                        result1 <= illegal_q ? '0 : alu_out;
                    end else begin
                        done0   <= 1'b1;
                        err0    <= illegal_q;
                        result0 <= illegal_q ? '0 : alu_out;
                    end
                    if (!illegal_q) op_count <= op_count + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; a behavioural ALU closes the loop on alu_a/alu_b/alu_op.
// Compile with ALU_ARB_ROUND_ROBIN_EN to expect round-robin tie-breaking.
module tb_alu_arbiter;

    localparam int W  = 16;
    localparam int OW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [OW-1:0] op0 = '0, op1 = '0;
    logic [W-1:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic          gnt0, gnt1, done0, done1, err0, err1, busy;
    logic [W-1:0]  result0, result1, alu_a, alu_b, alu_out;
    logic [OW-1:0] alu_op;
    logic [15:0]   op_count;
    logic [1:0]    state_dbg;

    int total = 0;
    int bad   = 0;

    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  exp_res [2];
    logic          exp_err [2];
    logic [15:0]   exp_cnt;
    logic [W-1:0]  exp_alu_a, exp_alu_b;
    logic [OW-1:0] exp_alu_op;

    alu_arbiter #(.WIDTH(W), .OPW(OW)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .err0(err0), .err1(err1), .result0(result0), .result1(result1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
        .busy(busy), .op_count(op_count), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clock = ~clock;

    function automatic logic [W-1:0] alu_model(input logic [OW-1:0] op,
                                               input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return {{(W-1){1'b0}}, ^a};
            default: return '0;
        endcase
    endfunction

    assign alu_out = alu_model(alu_op, alu_a, alu_b);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"},   busy,      0);
        check({tag, "_state"},  state_dbg, 0);
        check({tag, "_gnt0"},   gnt0,      0);
        check({tag, "_gnt1"},   gnt1,      0);
        check({tag, "_done0"},  done0,     0);
        check({tag, "_done1"},  done1,     0);
        check({tag, "_err0"},   err0,      0);
        check({tag, "_err1"},   err1,      0);
        check({tag, "_res0"},   result0,   0);
        check({tag, "_res1"},   result1,   0);
        check({tag, "_alu_a"},  alu_a,     0);
        check({tag, "_alu_b"},  alu_b,     0);
        check({tag, "_alu_op"}, alu_op,    0);
        check({tag, "_count"},  op_count,  0);
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_res[0] = '0; exp_res[1] = '0;
        exp_err[0] = 1'b0; exp_err[1] = 1'b0;
        exp_cnt = 16'd0;
        exp_alu_a = '0; exp_alu_b = '0; exp_alu_op = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
        tick();
        tick();
        model_reset();
        @(negedge clock);
        check_reset_state("rst");
        reset = 1'b0;
        tick();
    endtask

    // driver: one op from requester n, with hand-computed result and error flag
    task automatic issue_op(input int n, input logic [OW-1:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] exp_r, input logic exp_e);
        logic got;
        got = 1'b0;
        if (n == 0) begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
        else        begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
        exp_q.push_back(exp_r);
        for (int i = 0; i < 6 && !got; i++) begin
            @(negedge clock);
            got = (n == 0) ? gnt0 : gnt1;
        end
        if (!got) begin
            check("gnt_timeout", 0, 1);
            req0 = 1'b0; req1 = 1'b0;
            void'(exp_q.pop_front());
            return;
        end
        check("gnt_other", (n == 0) ? gnt1 : gnt0, 0);
        check("busy_exec", busy, 1);
        if (!exp_e) begin
            exp_alu_a = a; exp_alu_b = b; exp_alu_op = op;
        end
        check("alu_a", alu_a, exp_alu_a);
        check("alu_b", alu_b, exp_alu_b);
        check("alu_op", alu_op, exp_alu_op);
        tick();
        if (n == 0) req0 = 1'b0; else req1 = 1'b0;
        @(negedge clock);
        check("done_own", (n == 0) ? done0 : done1, 1);
        check("done_other", (n == 0) ? done1 : done0, 0);
        check("gnt_dropped", (n == 0) ? gnt0 : gnt1, 0);
        if (!exp_e) exp_cnt = exp_cnt + 16'd1;
        exp_res[n] = exp_q.pop_front();
        exp_err[n] = exp_e;
        check("result0", result0, exp_res[0]);
        check("result1", result1, exp_res[1]);
        check("err0", err0, exp_err[0]);
        check("err1", err1, exp_err[1]);
        check("op_count", op_count, exp_cnt);
        tick();
        @(negedge clock);
        check("done_pulse_end", (n == 0) ? done0 : done1, 0);
        check("busy_idle", busy, 0);
    endtask

    task automatic tie_test();
        logic    got;
        int      wait_n;
        int      w;
        req0 = 1'b1; op0 = 4'd1; a0 = 16'h0010; b0 = 16'h0001;
        req1 = 1'b1; op1 = 4'd2; a1 = 16'hF0F0; b1 = 16'h0FF0;
        for (int k = 0; k < 2; k++) begin
            wait_n = 0;
            got = 1'b0;
            while (!got && wait_n < 8) begin
                @(negedge clock);
                wait_n++;
                got = gnt0 | gnt1;
            end
            check("tie_gnt_seen", got, 1);
            if (!got) break;
            if (k == 1) check("tie_spacing", wait_n, 2);
`ifdef ALU_ARB_ROUND_ROBIN_EN
            w = k;
`else
            w = 0;
`endif
            check("tie_gnt0", gnt0, (w == 0));
            check("tie_gnt1", gnt1, (w == 1));
            @(negedge clock);
            if (w == 0) begin
                check("tie_done0", done0, 1);
                check("tie_result0", result0, 16'h000F);
            end else begin
                check("tie_done1", done1, 1);
                check("tie_result1", result1, 16'h00F0);
            end
        end
        tick();
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clock);
        check("tie_idle", busy, 0);
        check("tie_count", op_count, 2);
        tick();
        tick();
        check("tie_no_extra", busy, 0);
    endtask

    task automatic reset_in_exec_test();
        logic got;
        got = 1'b0;
        req1 = 1'b1; op1 = 4'd0; a1 = 16'h0011; b1 = 16'h0022;
        for (int i = 0; i < 6 && !got; i++) begin
            @(negedge clock);
            got = gnt1;
        end
        check("rexec_gnt1", got, 1);
        reset = 1'b1;
        req1 = 1'b0;
        @(negedge clock);
        check_reset_state("rexec");
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("rexec_no_done1", done1, 0);
        end
        check("rexec_still_idle", busy, 0);
    endtask

    initial begin
        model_reset();
        do_reset();

        issue_op(0, 4'd0, 16'h0003, 16'h0004, 16'h0007, 1'b0);
        issue_op(1, 4'd4, 16'h0007, 16'h0000, 16'h0001, 1'b0);
        issue_op(1, 4'd4, 16'h0003, 16'h0000, 16'h0000, 1'b0);
        issue_op(0, 4'd9, 16'h1234, 16'h5678, 16'h0000, 1'b1);
        issue_op(1, 4'd1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0);
        issue_op(0, 4'd3, 16'hA000, 16'h000A, 16'hA00A, 1'b0);
        issue_op(1, 4'd15, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1);
        issue_op(0, 4'd2, 16'hFF00, 16'h0FF0, 16'h0F00, 1'b0);

        // counter wrap: preload the count, then one legal op
        force dut.op_count = 16'hFFFF;
        #1;
        release dut.op_count;
        @(negedge clock);
        check("count_preload", op_count, 16'hFFFF);
        exp_cnt = 16'hFFFF;
        issue_op(0, 4'd0, 16'h0001, 16'h0001, 16'h0002, 1'b0);
        check("count_wrapped", op_count, 16'h0000);

        do_reset();
        tie_test();

        reset_in_exec_test();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits.
REQ-002 Parameter OPW, default 4, opcode width in bits.
REQ-003 clock  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0, req1  input  1 each  requester n wants an ALU operation.
REQ-006 op0, op1  input  OPW each  requested opcode (0 add, 1 sub, 2 and, 3 or, 4 epar).
REQ-007 a0, b0, a1, b1  input  WIDTH each  requester operands.
REQ-008 gnt0, gnt1  output  1 each  one-cycle pulse: request n accepted, operands latched.
REQ-009 done0, done1  output  1 each  one-cycle pulse: result n valid.
REQ-010 err0, err1  output  1 each  qualifies done n: opcode was illegal.
REQ-011 result0, result1  output  WIDTH each  registered result for requester n.
REQ-012 alu_a, alu_b  output  WIDTH each  registered operands driven to the shared ALU.
REQ-013 alu_op  output  OPW  registered opcode driven to the shared ALU.
REQ-014 alu_out  input  WIDTH  combinational ALU result.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 op_count  output  16  count of completed legal operations.

Function
REQ-017 FSM states IDLE, EXEC, DONE; IDLE->EXEC on any req sampled in IDLE, EXEC->DONE unconditionally, DONE->IDLE unconditionally.
REQ-018 req is sampled only in IDLE; requests arriving in EXEC or DONE wait.
REQ-019 Edge ending IDLE cycle N with a winner: latch winner id, opcode and operands; gnt_winner=1 for cycle N+1 only.
REQ-020 Cycle N+1 (EXEC): alu_a/alu_b/alu_op hold latched values; edge ending N+1 captures alu_out into result_winner.
REQ-021 Cycle N+2 (DONE): done_winner=1 for exactly one cycle; next acceptance earliest at edge ending N+3; throughput one op per 3 cycles.
REQ-022 Requester keeps req, op, a, b stable until gnt; must drop req by cycle N+2 unless issuing another op.
REQ-023 Opcode >4: alu_* not updated, result_winner=0, err_winner=1 with done_winner, op_count unchanged.
REQ-024 Legal opcode: err_winner=0 with done_winner; op_count increments by 1, wraps 0xFFFF->0x0000.
REQ-025 result_n and err_n hold value until next done_n; other requester's result/err untouched.
REQ-026 alu_a, alu_b, alu_op hold last issued values while IDLE/DONE.
REQ-027 gnt0/gnt1 never both high; done0/done1 never both high.
REQ-028 Only one op in flight; no queuing beyond the held req lines.

Reset
REQ-029 reset high at a rising edge forces: state IDLE, gnt*=0, done*=0, err*=0, result*=0, alu_a=alu_b=0, alu_op=0, op_count=0, last-grant=1.
REQ-030 Reset during EXEC or DONE discards the op in flight; no done pulse follows; reset dominates all other inputs.

Configuration
REQ-031 Macro ALU_ARB_ROUND_ROBIN_EN defined: on simultaneous req0/req1, grant the requester not granted last; last-grant updates on every grant.
REQ-032 Macro not defined: fixed priority, req0 always wins ties; last-grant register not implemented; single requests behave identically.

Verification
REQ-033 req0, op0=0, a0=0x0003, b0=0x0004 in IDLE -> gnt0 at N+1, alu_a=3/alu_b=4/alu_op=0 at N+1, done0 at N+2, result0=0x0007, err0=0, op_count=1.
REQ-034 Simultaneous req0 (op 1, 0x0010-0x0001) and req1 (op 2, 0xF0F0&0x0FF0) after reset, held -> RR: gnt0 first, result0=0x000F; then gnt1, result1=0x00F0; fixed-priority build: req0 repeats while held.
REQ-035 req1, op1=4, a1=0x0007 -> done1, result1=0x0001 (odd parity); a1=0x0003 -> result1=0x0000.
REQ-036 req0, op0=9 -> done0 with err0=1, result0=0, alu_op unchanged, op_count unchanged.
REQ-037 reset asserted in EXEC after gnt1 -> no done1, busy=0 next cycle, all outputs at reset values.
REQ-038 Preload 0xFFFF completed ops (or force op_count) then one legal op -> op_count=0x0000.
